// File: rtl/mips32i_pkg.sv
// Shared MIPS32 field definitions: format codes, field geometry, common opcodes
// and immediate/target range helpers used by the field encoder and decoder.
package mips32i_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_ILL = 2'd3
    } fmt_e;

    localparam int OPCODE_W   = 6;
    localparam int REG_W      = 5;
    localparam int SHAMT_W    = 5;
    localparam int FUNCT_W    = 6;
    localparam int IMM_W      = 16;
    localparam int TARGET_W   = 26;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;

    // Value lies in [-32768, 32767] when bits 31..15 are a pure sign extension.
    function automatic logic imm_fits_s16(input logic [31:0] v);
        return (v[31:15] == 17'h0_0000) || (v[31:15] == 17'h1_FFFF);
    endfunction

    function automatic logic imm_fits_u16(input logic [31:0] v);
        return (v[31:16] == 16'h0000);
    endfunction

    // Jump target must be word aligned and reachable within the 256 MB region.
    function automatic logic target_ok(input logic [31:0] v);
        return (v[1:0] == 2'b00) && (v[31:28] == 4'h0);
    endfunction

endpackage

// File: rtl/mips32i_encoder_if.sv
// Field-set input stream, address load port and encoded-word output stream
// of the MIPS32 instruction encoder.
interface mips32i_encoder_if #(parameter int ADDR_W = 32);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_fmt;
    logic [5:0]        in_opcode;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [31:0]       in_imm;
    logic              in_imm_signed;
    logic              load_addr;
    logic [ADDR_W-1:0] load_val;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, in_fmt, in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct,
               in_imm, in_imm_signed, load_addr, load_val, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct,
               in_imm, in_imm_signed, load_addr, load_val, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/mips32i_enc_fifo2.sv
// Two-entry valid/ready buffer. The head entry is a register driven straight
// to the output, and both handshake flags are registered.
module mips32i_enc_fifo2 #(
    parameter int           W         = 65,
    parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         push_ready,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);

    logic [1:0]   count_r;
    logic [1:0]   count_next_s;
    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;
    logic         ready_r;
    logic         valid_r;
    logic         push_s;
    logic         pop_s;

    assign push_s     = push_valid & ready_r;
    assign pop_s      = valid_r & pop_ready;
    assign push_ready = ready_r;
    assign pop_valid  = valid_r;
    assign pop_data   = head_r;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Storage and flags; a push with a pop can only happen at occupancy 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= RESET_VAL;
            tail_r  <= {W{1'b0}};
            count_r <= 2'd0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            count_r <= count_next_s;
            ready_r <= (count_next_s < 2'd2);
            valid_r <= (count_next_s != 2'd0);
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= push_data;
                    end else begin
                        tail_r <= push_data;
                    end
                end
                2'b01:   head_r <= tail_r;
                2'b11:   head_r <= push_data;
                default: head_r <= head_r;
            endcase
        end
    end

endmodule

// File: rtl/mips32i_encoder.sv
// Packs MIPS32 R/I/J fields into instruction words tagged with a byte address.
// Define MIPS32I_ENC_CHECK_EN to flag out-of-range immediates and jump targets.
module mips32i_encoder
    import mips32i_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    mips32i_encoder_if.slave bus
);

    localparam int ENTRY_W = 32 + ADDR_W + 1;

    logic [31:0]        instr_s;
    logic               range_err_s;
    logic               err_s;
    logic               accept_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [ADDR_W-1:0]  stamp_s;
    logic [ADDR_W-1:0]  addr_next_s;
    logic [ENTRY_W-1:0] pop_data_s;

    // Field packing; fields outside the selected format are ignored.
    always_comb begin
        instr_s = 32'h0000_0000;
        case (fmt_e'(bus.in_fmt))
            FMT_R:   instr_s = {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_rd,
                                bus.in_shamt, bus.in_funct};
            FMT_I:   instr_s = {bus.in_opcode, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
            FMT_J:   instr_s = {bus.in_opcode, bus.in_imm[27:2]};
            default: instr_s = 32'h0000_0000;
        endcase
    end

`ifdef MIPS32I_ENC_CHECK_EN
    // Range checks on the values that packing truncates.
    always_comb begin
        range_err_s = 1'b0;
        case (fmt_e'(bus.in_fmt))
            FMT_I:   range_err_s = bus.in_imm_signed ? !imm_fits_s16(bus.in_imm)
                                                     : !imm_fits_u16(bus.in_imm);
            FMT_J:   range_err_s = !target_ok(bus.in_imm);
            default: range_err_s = 1'b0;
        endcase
    end
`else
    assign range_err_s = 1'b0;
`endif

    assign err_s    = (fmt_e'(bus.in_fmt) == FMT_ILL) | range_err_s;
    assign accept_s = bus.in_valid & bus.in_ready;

    // A load in the accept cycle both stamps this word and rebases the counter.
    always_comb begin
        stamp_s     = bus.load_addr ? bus.load_val : addr_r;
        addr_next_s = addr_r;
        if (accept_s) begin
            addr_next_s = stamp_s + ADDR_W'(3'd4);
        end else if (bus.load_addr) begin
            addr_next_s = bus.load_val;
        end else begin
            addr_next_s = addr_r;
        end
    end

    // Address of the next accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= RESET_ADDR;
        end else begin
            addr_r <= addr_next_s;
        end
    end

    mips32i_enc_fifo2 #(
        .W         (ENTRY_W),
        .RESET_VAL ({1'b0, RESET_ADDR, 32'h0000_0000})
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (bus.in_valid),
        .push_data  ({err_s, stamp_s, instr_s}),
        .push_ready (bus.in_ready),
        .pop_valid  (bus.out_valid),
        .pop_ready  (bus.out_ready),
        .pop_data   (pop_data_s)
    );

    assign bus.out_instr = pop_data_s[31:0];
    assign bus.out_addr  = pop_data_s[32 +: ADDR_W];
    assign bus.out_err   = pop_data_s[ENTRY_W-1];

endmodule

// File: tb/tb_mips32i_encoder.sv
// Self-checking bench for mips32i_encoder: directed cases with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_mips32i_encoder;
    import mips32i_pkg::*;

    localparam int          AW       = 32;
    localparam logic [31:0] RST_ADDR = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips32i_encoder_if #(.ADDR_W(AW)) bus_if ();

    mips32i_encoder #(.ADDR_W(AW), .RESET_ADDR(RST_ADDR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } word_t;

    word_t       mq[$];
    word_t       obs[$];
    logic [31:0] mctr;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    bit          chk_on = 1'b0;
    bit          rec_on = 1'b0;

    // Expected word from the format rules, using plain integer arithmetic.
    function automatic word_t model_word(input int fmt, input int op, input int rs, input int rt,
                                         input int rd, input int sh, input int fn,
                                         input logic [31:0] imm, input bit sgn,
                                         input logic [31:0] addr);
        word_t w;
        longint unsigned base, u;
        longint sv;
        base = longint'(op) * 64'd67108864 + longint'(rs) * 64'd2097152 + longint'(rt) * 64'd65536;
        u    = {32'd0, imm};
        sv   = longint'($signed(imm));
        w.addr = addr;
        w.err  = 1'b0;
        case (fmt)
            0: w.instr = 32'(base + longint'(rd) * 64'd2048 + longint'(sh) * 64'd64 + longint'(fn));
            1: begin
                w.instr = 32'(base + u % 64'd65536);
`ifdef MIPS32I_ENC_CHECK_EN
                w.err = sgn ? (sv < -64'sd32768 || sv > 64'sd32767) : (u > 64'd65535);
`endif
            end
            2: begin
                w.instr = 32'(longint'(op) * 64'd67108864 + (u / 64'd4) % 64'd67108864);
`ifdef MIPS32I_ENC_CHECK_EN
                w.err = (u % 64'd4 != 0) || (u >= 64'd268435456);
`endif
            end
            default: begin
                w.instr = 32'h0;
                w.err   = 1'b1;
            end
        endcase
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks buffer contents and the address counter.
    initial begin
        mctr = RST_ADDR;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                mctr = RST_ADDR;
            end else begin
                bit          acc, pop;
                logic [31:0] stamp;
                acc   = bus_if.in_valid && (mq.size() < 2);
                pop   = (mq.size() != 0) && bus_if.out_ready;
                stamp = bus_if.load_addr ? bus_if.load_val : mctr;
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back(model_word(int'(bus_if.in_fmt), int'(bus_if.in_opcode),
                                                 int'(bus_if.in_rs), int'(bus_if.in_rt),
                                                 int'(bus_if.in_rd), int'(bus_if.in_shamt),
                                                 int'(bus_if.in_funct), bus_if.in_imm,
                                                 bus_if.in_imm_signed, stamp));
                if (acc) mctr = stamp + 32'd4;
                else if (bus_if.load_addr) mctr = bus_if.load_val;
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            chk("in_ready", {31'd0, bus_if.in_ready}, {31'd0, mq.size() < 2});
            chk("out_valid", {31'd0, bus_if.out_valid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("out_instr", bus_if.out_instr, mq[0].instr);
                chk("out_addr", bus_if.out_addr, mq[0].addr);
                chk("out_err", {31'd0, bus_if.out_err}, {31'd0, mq[0].err});
            end
            if (rec_on && bus_if.out_valid && bus_if.out_ready)
                obs.push_back('{bus_if.out_instr, bus_if.out_addr, bus_if.out_err});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_word(input int fmt, input int op, input int rs, input int rt, input int rd,
                            input int sh, input int fn, input logic [31:0] imm, input bit sgn);
        bus_if.in_fmt        = 2'(fmt);
        bus_if.in_opcode     = 6'(op);
        bus_if.in_rs         = 5'(rs);
        bus_if.in_rt         = 5'(rt);
        bus_if.in_rd         = 5'(rd);
        bus_if.in_shamt      = 5'(sh);
        bus_if.in_funct      = 6'(fn);
        bus_if.in_imm        = imm;
        bus_if.in_imm_signed = sgn;
    endtask

    // Hold in_valid until the DUT takes the word, within a cycle budget.
    task automatic wait_accept(input string name);
        bit ok;
        logic r;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            r = bus_if.in_ready;
            step();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: accept timeout, got no in_ready expected in_ready", name);
        end
    endtask

    task automatic send(input string name);
        bus_if.in_valid = 1'b1;
        wait_accept(name);
        bus_if.in_valid = 1'b0;
    endtask

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        bus_if.load_addr = 1'b0;
        bus_if.load_val  = 32'h0;
        set_word(0, 0, 0, 0, 0, 0, 0, 32'h0, 1'b0);

        #12;
        chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        chk("rst_out_instr", bus_if.out_instr, 32'h0);
        chk("rst_out_addr", bus_if.out_addr, RST_ADDR);
        chk("rst_out_err", {31'd0, bus_if.out_err}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        step();

        set_word(0, OP_RTYPE, 1, 2, 3, 0, FN_ADD, 32'h0, 1'b0);
        send("r_add");
        @(negedge clk);
        chk("r_add_instr", bus_if.out_instr, 32'h0022_1820);
        chk("r_add_addr", bus_if.out_addr, 32'h0);
        chk("r_add_err", {31'd0, bus_if.out_err}, 32'd0);

        step();
        set_word(1, OP_ADDI, 1, 2, 0, 0, 0, 32'hFFFF_FFFF, 1'b1);
        send("addi_m1");
        @(negedge clk);
        chk("addi_m1_instr", bus_if.out_instr, 32'h2022_FFFF);
        chk("addi_m1_addr", bus_if.out_addr, 32'h4);
        chk("addi_m1_err", {31'd0, bus_if.out_err}, 32'd0);

        step();
        set_word(1, OP_ADDI, 1, 2, 0, 0, 0, 32'd40000, 1'b1);
        send("addi_40000");
        @(negedge clk);
        chk("addi_40000_instr", bus_if.out_instr, 32'h2022_9C40);
`ifdef MIPS32I_ENC_CHECK_EN
        chk("addi_40000_err", {31'd0, bus_if.out_err}, 32'd1);
`else
        chk("addi_40000_err", {31'd0, bus_if.out_err}, 32'd0);
`endif

        step();
        set_word(2, OP_J, 0, 0, 0, 0, 0, 32'h0040_0000, 1'b0);
        send("j_ok");
        @(negedge clk);
        chk("j_ok_instr", bus_if.out_instr, 32'h0810_0000);
        chk("j_ok_err", {31'd0, bus_if.out_err}, 32'd0);

        step();
        set_word(2, OP_J, 0, 0, 0, 0, 0, 32'h0040_0002, 1'b0);
        send("j_misalign");
        @(negedge clk);
        chk("j_misalign_instr", bus_if.out_instr, 32'h0810_0000);
`ifdef MIPS32I_ENC_CHECK_EN
        chk("j_misalign_err", {31'd0, bus_if.out_err}, 32'd1);
`else
        chk("j_misalign_err", {31'd0, bus_if.out_err}, 32'd0);
`endif

        step();
        set_word(3, 5, 1, 1, 1, 1, 1, 32'h1234_5678, 1'b0);
        send("illegal");
        @(negedge clk);
        chk("illegal_instr", bus_if.out_instr, 32'h0);
        chk("illegal_err", {31'd0, bus_if.out_err}, 32'd1);

        // Back-pressure: restart from reset, three back-to-back words, sink stalled 4 cycles.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        set_word(0, OP_RTYPE, 1, 2, 3, 0, FN_ADD, 32'h0, 1'b0);
        step();
        set_word(1, OP_ADDI, 1, 2, 0, 0, 0, 32'd5, 1'b0);
        step();
        @(negedge clk);
        chk("bp_in_ready_full", {31'd0, bus_if.in_ready}, 32'd0);
        chk("bp_head_addr", bus_if.out_addr, 32'h0);
        set_word(2, OP_J, 0, 0, 0, 0, 0, 32'h0040_0000, 1'b0);
        step();
        step();
        obs.delete();
        rec_on = 1'b1;
        bus_if.out_ready = 1'b1;
        wait_accept("bp_third");
        bus_if.in_valid = 1'b0;
        repeat (4) step();
        rec_on = 1'b0;
        chk("bp_drain_count", obs.size(), 32'd3);
        if (obs.size() == 3) begin
            chk("bp_w0_instr", obs[0].instr, 32'h0022_1820);
            chk("bp_w0_addr", obs[0].addr, 32'h0);
            chk("bp_w1_instr", obs[1].instr, 32'h2022_0005);
            chk("bp_w1_addr", obs[1].addr, 32'h4);
            chk("bp_w2_instr", obs[2].instr, 32'h0810_0000);
            chk("bp_w2_addr", obs[2].addr, 32'h8);
        end

        // Address load together with an accept, then one more accept.
        bus_if.load_addr = 1'b1;
        bus_if.load_val  = 32'h0000_0100;
        set_word(0, OP_RTYPE, 4, 5, 6, 0, FN_ADD, 32'h0, 1'b0);
        send("load_first");
        bus_if.load_addr = 1'b0;
        @(negedge clk);
        chk("load_first_addr", bus_if.out_addr, 32'h0000_0100);
        step();
        send("load_second");
        @(negedge clk);
        chk("load_second_addr", bus_if.out_addr, 32'h0000_0104);

        // Reset with two words buffered.
        step();
        bus_if.out_ready = 1'b0;
        set_word(0, OP_RTYPE, 1, 1, 1, 0, FN_ADD, 32'h0, 1'b0);
        send("midrst_a");
        send("midrst_b");
        @(negedge clk);
        chk("midrst_pre_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        bus_if.out_ready = 1'b1;
        set_word(0, OP_RTYPE, 1, 2, 3, 0, FN_ADD, 32'h0, 1'b0);
        send("post_rst");
        @(negedge clk);
        chk("post_rst_addr", bus_if.out_addr, RST_ADDR);
        chk("post_rst_instr", bus_if.out_instr, 32'h0022_1820);

        // Randomized traffic against the model.
        step();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] imm;
            case ($urandom_range(0, 4))
                0: imm = $urandom_range(0, 70000);
                1: imm = 32'(-$signed($urandom_range(0, 40000)));
                2: imm = {4'h0, 26'($urandom), 2'b00};
                3: imm = {4'h0, 28'($urandom)};
                default: imm = $urandom;
            endcase
            set_word($urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 63), imm, 1'($urandom_range(0, 1)));
            bus_if.in_valid  = ($urandom_range(0, 3) != 0);
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            bus_if.load_addr = ($urandom_range(0, 31) == 0);
            bus_if.load_val  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step();
        end
        bus_if.in_valid  = 1'b0;
        bus_if.load_addr = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
